uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_PER_BIT, default 87, clock cycles per serial bit; legal range 4..65535.
REQ-002 Parameter PARITY_EN, default 0, 1 appends a parity bit after bit 7.
REQ-003 Parameter PARITY_ODD, default 0, 1 selects odd parity and 0 selects even; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 i_data  input  8  byte to transmit; sampled only on the accept cycle.
REQ-008 i_valid  input  1  requester has a byte on i_data.
REQ-009 o_ready  output  1  block can accept a byte this cycle.
REQ-010 o_tx  output  1  serial line; idle high, LSB first.
REQ-011 o_busy  output  1  a frame is in progress.
REQ-012 o_done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 Accept SHALL occur on a rising edge where i_valid=1 and o_ready=1; i_data is latched into an internal shift register on that edge.
REQ-014 o_ready SHALL be 1 only in state IDLE; i_valid while o_ready=0 SHALL be ignored, with no queuing.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP; any unused encoding SHALL return to IDLE on the next edge.
REQ-016 IDLE: o_tx=1; on accept go to START with bit counter=0 and clock counter=0.
REQ-017 START: o_tx=0 for exactly CLK_PER_BIT cycles, then go to DATA.
REQ-018 DATA: o_tx=data[bit_index] for CLK_PER_BIT cycles per bit, bit_index 0..7; after bit 7 go to PARITY if PARITY_EN=1, else go to STOP.
REQ-019 PARITY: o_tx = XOR of the 8 latched bits XOR PARITY_ODD, held for CLK_PER_BIT cycles, then go to STOP.
REQ-020 STOP: o_tx=1 for STOP_BITS*CLK_PER_BIT cycles, then go to IDLE.
REQ-021 o_tx SHALL be driven from a register (no combinational path from i_data/i_valid); the first START-bit low appears on the edge that performs the accept.
REQ-022 Frame length from the accept edge to IDLE re-entry SHALL be (10 + PARITY_EN + STOP_BITS - 1)*CLK_PER_BIT cycles exactly.
REQ-023 The clock counter SHALL be clog2(CLK_PER_BIT) bits wide, count 0..CLK_PER_BIT-1, and wrap to 0 at each bit boundary with no off-by-one cycle.
REQ-024 o_done SHALL pulse high for exactly one cycle, on the cycle the FSM is first in IDLE after STOP.
REQ-025 o_busy SHALL be 1 in every state other than IDLE.
REQ-026 Back-to-back: if i_valid is held high, the next accept SHALL occur on the first IDLE cycle, giving exactly one extra idle-high cycle between frames.
REQ-027 Changes on i_data after the accept edge SHALL NOT affect the frame in flight.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, o_tx=1, o_ready=0, o_busy=0, o_done=0, and all counters and the shift register to 0.
REQ-029 o_ready SHALL rise on the first rising clk edge after rst is deasserted.
REQ-030 rst asserted mid-frame SHALL abort the frame: o_tx returns high at once, no o_done pulse occurs, and no partial frame resumes after release.

Verification
REQ-031 CLK_PER_BIT=4, PARITY_EN=0, STOP_BITS=1; send 0x55 -> o_tx = 0,1,0,1,0,1,0,1,0,1 (4 cycles each); o_done on cycle 40 after accept; o_ready=0 throughout.
REQ-032 CLK_PER_BIT=4, PARITY_EN=1, PARITY_ODD=0; send 0x07 -> parity bit=1; with PARITY_ODD=1, send 0x07 -> parity bit=0; frame is 44 cycles.
REQ-033 STOP_BITS=2, i_valid held high with 0xA5 then 0x3C -> line high for 8 cycles + 1 idle cycle between frames; both bytes decode correctly with the LSB first.
REQ-034 Assert rst on cycle 13 of a 0xFF frame -> o_tx=1 within the same cycle, o_busy=0, no o_done pulse; after release, o_ready=1 on the next edge and a new frame of 0x00 is sent correctly.
REQ-035 Pulse i_valid while o_busy=1 with a different byte -> that byte is never transmitted, and the current frame is bit-exact.
REQ-036 Change i_data every cycle after accept -> the transmitted byte equals the value present at the accept edge.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte request handshake plus serial line and status of the UART transmitter.
// Latency: none, this is wiring only.
// Backpressure: the requester holds i_valid until o_ready is seen at a rising edge.
interface uart_tx_if;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready,
    input  o_tx,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready,
    output o_tx,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Latency: the start bit drives the line on the accept edge; a frame is (10+PARITY_EN+STOP_BITS-1)*CLK_PER_BIT cycles.
// Backpressure: o_ready is high only while idle; requests made while a frame is in flight are dropped, not queued.
module uart_tx #(
  parameter int CLK_PER_BIT = 87,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);

  localparam int            CW        = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic          PAR_EN    = (PARITY_EN != 0);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic [2:0]    STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tx_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic          bit_end;

  // A serial bit period ends when the cycle counter reaches its last value.
  assign bit_end = (clk_cnt == CNT_LAST);

  // Frame sequencer: every output is a register, so the line never sees i_data/i_valid combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (bus.i_valid && ready_q) begin
            // Start bit goes out on the accept edge itself.
            shreg   <= bus.i_data;
            state   <= S_START;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= S_DATA;
            tx_q    <= shreg[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (PAR_EN) begin
                state <= S_PARITY;
                tx_q  <= (^shreg) ^ PAR_ODD;
              end else begin
                state <= S_STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= shreg[bit_cnt + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          // bit_cnt counts stop bits here so two stop bits reuse the same period counter.
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= S_IDLE;
              tx_q    <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          clk_cnt <= '0;
          bit_cnt <= '0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_tx    = tx_q;
  assign bus.o_ready = ready_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx over several parameter sets sharing one clock and reset.
// Latency: expected line levels come from a frame-level model indexed by cycle since accept.
// Backpressure: requests are driven only when the targeted instance reports ready.
module tb_uart_tx;

  localparam int NDUT = 5;

  function automatic int cpb_of(input int k);
    case (k)
      4:       return 7;
      default: return 4;
    endcase
  endfunction

  function automatic int pe_of(input int k);
    case (k)
      1, 2, 4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int podd_of(input int k);
    case (k)
      2, 4:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int sb_of(input int k);
    case (k)
      3, 4:    return 2;
      default: return 1;
    endcase
  endfunction

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      data_a [NDUT];
  logic [NDUT-1:0] valid_v;
  logic [NDUT-1:0] tx_v;
  logic [NDUT-1:0] busy_v;
  logic [NDUT-1:0] ready_v;
  logic [NDUT-1:0] done_v;

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < NDUT; g++) begin : gd
    uart_tx_if bus ();
    assign bus.i_data  = data_a[g];
    assign bus.i_valid = valid_v[g];
    assign tx_v[g]     = bus.o_tx;
    assign busy_v[g]   = bus.o_busy;
    assign ready_v[g]  = bus.o_ready;
    assign done_v[g]   = bus.o_done;

    uart_tx #(
      .CLK_PER_BIT (cpb_of(g)),
      .PARITY_EN   (pe_of(g)),
      .PARITY_ODD  (podd_of(g)),
      .STOP_BITS   (sb_of(g))
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // {tx, busy, ready, done} of one instance.
  function automatic logic [3:0] st(input int k);
    return {tx_v[k], busy_v[k], ready_v[k], done_v[k]};
  endfunction

  function automatic int frame_bits(input int k);
    return 10 + pe_of(k) + sb_of(k) - 1;
  endfunction

  // Line level during serial bit i of a frame carrying byte b.
  function automatic logic exp_bit(input int k, input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9 && pe_of(k) != 0) return (^b) ^ (podd_of(k) != 0);
    return 1'b1;
  endfunction

  // Entered at the first sample after the accept edge; leaves at the o_done sample.
  // mode 0 plain, 1 jam other bytes while busy, 2 scramble i_data, 3 hold i_valid with next byte.
  task automatic frame_body(input int k, input logic [7:0] b, input int mode, input logic [7:0] nxt);
    int len;
    len = frame_bits(k) * cpb_of(k);
    for (int c = 0; c < len; c++) begin
      chk("frame", st(k), {exp_bit(k, b, c / cpb_of(k)), 3'b100});
      case (mode)
        1: begin
          valid_v[k] = (c == 7) || (c == 20);
          data_a[k]  = ~b;
        end
        2: data_a[k] = 8'($urandom);
        3: begin
          valid_v[k] = 1'b1;
          data_a[k]  = nxt;
        end
        default: ;
      endcase
      @(negedge clk);
    end
    chk("done_pulse", st(k), 4'b1011);
  endtask

  task automatic send(input int k, input logic [7:0] b, input int mode, input logic [7:0] nxt);
    chk("ready_before_send", ready_v[k], 1'b1);
    data_a[k]  = b;
    valid_v[k] = 1'b1;
    @(negedge clk);
    if (mode != 3) valid_v[k] = 1'b0;
    frame_body(k, b, mode, nxt);
  endtask

  task automatic idle_chk(input int k);
    @(negedge clk);
    chk("idle_after_done", st(k), 4'b1010);
  endtask

  task automatic reset_mid(input int k, input logic [7:0] b, input int cyc);
    chk("ready_before_send", ready_v[k], 1'b1);
    data_a[k]  = b;
    valid_v[k] = 1'b1;
    @(negedge clk);
    valid_v[k] = 1'b0;
    for (int c = 0; c < cyc; c++) begin
      chk("pre_reset", st(k), {exp_bit(k, b, c / cpb_of(k)), 3'b100});
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("reset_async", st(k), 4'b1000);
    repeat (3) begin
      @(negedge clk);
      chk("in_reset", st(k), 4'b1000);
    end
    rst = 1'b0;
    #1;
    chk("ready_before_edge", ready_v[k], 1'b0);
    @(negedge clk);
    chk("post_reset", st(k), 4'b1010);
    @(negedge clk);
    chk("no_resume", st(k), 4'b1010);
  endtask

  initial begin
    int k;
    int mode;
    logic [7:0] b;
    rst     = 1'b1;
    valid_v = '0;
    for (int i = 0; i < NDUT; i++) data_a[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) chk("reset_state", st(i), 4'b1000);
    rst = 1'b0;
    #1;
    chk("ready_before_edge", ready_v[0], 1'b0);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) chk("ready_after_release", st(i), 4'b1010);

    // 8N1 with 0x55: alternating line, o_done 40 cycles after accept.
    send(0, 8'h55, 0, 8'h00);
    idle_chk(0);
    // Even then odd parity on 0x07.
    send(1, 8'h07, 0, 8'h00);
    idle_chk(1);
    send(2, 8'h07, 0, 8'h00);
    idle_chk(2);
    // Two stop bits, i_valid held: exactly one idle cycle between frames.
    send(3, 8'hA5, 3, 8'h3C);
    @(negedge clk);
    valid_v[3] = 1'b0;
    frame_body(3, 8'h3C, 0, 8'h00);
    idle_chk(3);
    // Reset mid-frame, then a clean 0x00 frame.
    reset_mid(0, 8'hFF, 12);
    send(0, 8'h00, 0, 8'h00);
    idle_chk(0);
    reset_mid(1, 8'h5A, 2);
    send(1, 8'h5A, 0, 8'h00);
    idle_chk(1);
    // Requests while busy are dropped; data changes after accept are ignored.
    send(0, 8'h96, 1, 8'h00);
    idle_chk(0);
    send(4, 8'hC3, 2, 8'h00);
    idle_chk(4);

    for (int n = 0; n < 40; n++) begin
      k    = int'($urandom_range(0, NDUT - 1));
      mode = int'($urandom_range(0, 2));
      b    = 8'($urandom);
      send(k, b, mode, 8'h00);
      idle_chk(k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
